// File: rtl/id_stage.sv
// id_stage: IF/ID pipeline register and instruction decoder.
// LM/SM are expanded into one single-register micro-op per cycle while fetch is held.
module id_stage #(
    parameter int REG_AW = 3,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              stall_in,
    input  logic [15:0]       instr_in,
    input  logic [15:0]       pc_in,
    output logic              fetch_hold,
    output logic              valid_out,
    output logic [15:0]       pc_out,
    output logic [3:0]        opcode_out,
    output logic [REG_AW-1:0] rd_addr,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    output logic [IMM_W-1:0]  imm_out,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              is_branch,
    output logic              is_jump,
    output logic [1:0]        cz_out,
    output logic              illegal_out
);
    typedef enum logic {RUN, MULTI} state_t;
    typedef struct packed {
        logic              valid;
        logic [15:0]       pc;
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [IMM_W-1:0]  imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              is_branch;
        logic              is_jump;
        logic [1:0]        cz;
        logic              illegal;
    } dec_t;

    state_t            st_q, st_d;
    dec_t              dec_q, dec_d;
    logic [7:0]        mask_q, mask_d, mask_v, mask_rest;
    logic [2:0]        cnt_q, cnt_d, idx;
    logic              multi_busy_q;
    logic              uop, ill;
    logic [3:0]        op;
    logic [REG_AW-1:0] ra, rb, rc;
    logic [IMM_W-1:0]  sext6, sext9;

    assign op    = instr_in[15:12];
    assign ra    = REG_AW'(instr_in[11:9]);
    assign rb    = REG_AW'(instr_in[8:6]);
    assign rc    = REG_AW'(instr_in[5:3]);
    assign sext6 = IMM_W'($signed(instr_in[5:0]));
    assign sext9 = IMM_W'($signed(instr_in[8:0]));

    assign fetch_hold = stall_in | multi_busy_q;

    always_comb begin
        st_d   = st_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        dec_d  = dec_q;
        uop    = 1'b0;
        ill    = 1'b0;
        mask_v = (st_q == RUN) ? instr_in[7:0] : mask_q;
        idx    = '0;
        for (int i = 7; i >= 0; i--)
            if (mask_v[i]) idx = 3'(i);
        mask_rest = mask_v & ~(8'b1 << idx);
        if (flush) begin
            st_d   = RUN;
            mask_d = '0;
            cnt_d  = '0;
            dec_d  = '0;
        end else if (!stall_in) begin
            if (st_q == MULTI) begin
                uop = 1'b1;
            end else begin
                dec_d        = '0;
                dec_d.pc     = pc_in;
                dec_d.opcode = op;
                dec_d.valid  = instr_in != 16'h0000;
                if (dec_d.valid) begin
                    case (op)
                        4'b0001, 4'b0010: begin
                            dec_d.rd = rc; dec_d.rs1 = ra; dec_d.rs2 = rb;
                            dec_d.reg_write = 1'b1; dec_d.cz = instr_in[1:0];
                        end
                        4'b0000: begin
                            dec_d.rd = rb; dec_d.rs1 = ra; dec_d.imm = sext6; dec_d.reg_write = 1'b1;
                        end
                        4'b0011: begin
                            dec_d.rd = ra; dec_d.imm = IMM_W'({instr_in[8:0], 7'b0}); dec_d.reg_write = 1'b1;
                        end
                        4'b0100: begin
                            dec_d.rd = ra; dec_d.rs1 = rb; dec_d.imm = sext6;
                            dec_d.reg_write = 1'b1; dec_d.mem_read = 1'b1;
                        end
                        4'b0101: begin
                            dec_d.rs1 = rb; dec_d.rs2 = ra; dec_d.imm = sext6; dec_d.mem_write = 1'b1;
                        end
                        4'b1000: begin
                            dec_d.rs1 = ra; dec_d.rs2 = rb; dec_d.imm = sext6; dec_d.is_branch = 1'b1;
                        end
                        4'b1001: begin
                            dec_d.rd = ra; dec_d.imm = sext9; dec_d.reg_write = 1'b1; dec_d.is_jump = 1'b1;
                        end
                        4'b1010: begin
                            dec_d.rd = ra; dec_d.rs1 = rb; dec_d.reg_write = 1'b1; dec_d.is_jump = 1'b1;
                        end
                        4'b1011: begin
                            dec_d.rs1 = ra; dec_d.imm = sext9; dec_d.is_jump = 1'b1;
                        end
                        4'b1100, 4'b1101: begin
                            uop             = |mask_v;
                            dec_d.valid     = uop;
                            dec_d.rs1       = ra;
                            dec_d.reg_write = uop & (op == 4'b1100);
                            dec_d.mem_read  = uop & (op == 4'b1100);
                            dec_d.mem_write = uop & (op == 4'b1101);
                        end
                        default: begin
                            dec_d.valid   = 1'b0;
                            dec_d.illegal = 1'b1;
                        end
                    endcase
                end
                if (!dec_d.valid) begin
                    ill           = dec_d.illegal;
                    dec_d         = '0;
                    dec_d.illegal = ill;
                end
            end
        end
        // Shared by the first micro-op (RUN) and the rest (MULTI); count is always 0 in RUN.
        if (uop) begin
            if (dec_d.opcode == 4'b1100) dec_d.rd = REG_AW'(idx);
            else dec_d.rs2 = REG_AW'(idx);
            dec_d.imm = IMM_W'(cnt_q);
            mask_d    = mask_rest;
            cnt_d     = (|mask_rest) ? cnt_q + 3'd1 : 3'd0;
            st_d      = (|mask_rest) ? MULTI : RUN;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q         <= RUN;
            dec_q        <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            multi_busy_q <= 1'b0;
        end else begin
            st_q         <= st_d;
            dec_q        <= dec_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            multi_busy_q <= st_d == MULTI;
        end
    end

    assign valid_out   = dec_q.valid;
    assign pc_out      = dec_q.pc;
    assign opcode_out  = dec_q.opcode;
    assign rd_addr     = dec_q.rd;
    assign rs1_addr    = dec_q.rs1;
    assign rs2_addr    = dec_q.rs2;
    assign imm_out     = dec_q.imm;
    assign reg_write   = dec_q.reg_write;
    assign mem_read    = dec_q.mem_read;
    assign mem_write   = dec_q.mem_write;
    assign is_branch   = dec_q.is_branch;
    assign is_jump     = dec_q.is_jump;
    assign cz_out      = dec_q.cz;
    assign illegal_out = dec_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table-driven bench for id_stage with a scoreboard queue of expected outputs.
module tb_id_stage;
    logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0, stall_in = 1'b0;
    logic [15:0] instr_in = 16'h1A4B, pc_in = 16'h0000;
    logic        fetch_hold, valid_out, reg_write, mem_read, mem_write, is_branch, is_jump, illegal_out;
    logic [15:0] pc_out, imm_out;
    logic [3:0]  opcode_out;
    logic [2:0]  rd_addr, rs1_addr, rs2_addr;
    logic [1:0]  cz_out;

    id_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall_in(stall_in),
        .instr_in(instr_in), .pc_in(pc_in), .fetch_hold(fetch_hold),
        .valid_out(valid_out), .pc_out(pc_out), .opcode_out(opcode_out),
        .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm_out(imm_out),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .is_jump(is_jump), .cz_out(cz_out), .illegal_out(illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hold;
        logic        valid;
        logic [15:0] pc;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic [4:0]  strb;
        logic [1:0]  cz;
        logic        ill;
    } o_t;
    typedef struct {
        logic [15:0] ins, pc;
        logic        fl, st;
        o_t          ex;
    } vec_t;

    localparam logic [4:0] RW = 5'b10000, MR = 5'b01000, MW = 5'b00100, BR = 5'b00010, JP = 5'b00001;

    int   total = 0, bad = 0;
    vec_t vt[$];
    o_t   sb[$];

    function automatic o_t mk(input logic h, v, input logic [15:0] pc, input logic [3:0] op,
                              input logic [2:0] rd, rs1, rs2, input logic [15:0] imm,
                              input logic [4:0] s, input logic [1:0] cz, input logic ill);
        o_t r;
        r = {h, v, pc, op, rd, rs1, rs2, imm, s, cz, ill};
        return r;
    endfunction

    function automatic o_t cur();
        o_t r;
        r = {fetch_hold, valid_out, pc_out, opcode_out, rd_addr, rs1_addr, rs2_addr, imm_out,
             {reg_write, mem_read, mem_write, is_branch, is_jump}, cz_out, illegal_out};
        return r;
    endfunction

    function automatic void add(input logic [15:0] ins, pc, input logic fl, st, input o_t ex);
        vec_t r;
        r.ins = ins; r.pc = pc; r.fl = fl; r.st = st; r.ex = ex;
        vt.push_back(r);
    endfunction

    task automatic check(input string nm, input o_t ex);
        o_t got;
        got = cur();
        total++;
        if (got !== ex) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, ex);
        end
    endtask

    task automatic step(input string nm, input logic [15:0] ins, pc, input logic fl, st, input o_t ex);
        instr_in = ins; pc_in = pc; flush = fl; stall_in = st;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        check(nm, sb.pop_front());
    endtask

    initial begin
        o_t z;
        z = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_zero", z);
        stall_in = 1'b1;
        #1;
        z.hold = 1'b1;
        check("reset_hold", z);
        stall_in = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        add(16'h1A4B, 16'h0010, 0, 0, mk(0, 1, 16'h0010, 4'h1, 1, 5, 1, 16'h0000, RW, 2'b11, 0));
        add(16'h0A7E, 16'h0012, 0, 0, mk(0, 1, 16'h0012, 4'h0, 1, 5, 0, 16'hFFFE, RW, 0, 0));
        add(16'hB1FF, 16'h0014, 0, 0, mk(0, 1, 16'h0014, 4'hB, 0, 0, 0, 16'hFFFF, JP, 0, 0));
        add(16'h2C1A, 16'h0016, 0, 0, mk(0, 1, 16'h0016, 4'h2, 3, 6, 0, 16'h0000, RW, 2'b10, 0));
        add(16'h3701, 16'h0018, 0, 0, mk(0, 1, 16'h0018, 4'h3, 3, 0, 0, 16'h8080, RW, 0, 0));
        add(16'h4A85, 16'h001A, 0, 0, mk(0, 1, 16'h001A, 4'h4, 5, 2, 0, 16'h0005, RW | MR, 0, 0));
        add(16'h5660, 16'h001C, 0, 0, mk(0, 1, 16'h001C, 4'h5, 0, 1, 3, 16'hFFE0, MW, 0, 0));
        add(16'h8C7F, 16'h001E, 0, 0, mk(0, 1, 16'h001E, 4'h8, 0, 6, 1, 16'hFFFF, BR, 0, 0));
        add(16'h9E40, 16'h0020, 0, 0, mk(0, 1, 16'h0020, 4'h9, 7, 0, 0, 16'h0040, RW | JP, 0, 0));
        add(16'hA4C0, 16'h0022, 0, 0, mk(0, 1, 16'h0022, 4'hA, 2, 3, 0, 16'h0000, RW | JP, 0, 0));
        add(16'hE000, 16'h0024, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add(16'h0000, 16'h0026, 0, 0, '0);
        add(16'hD200, 16'h0028, 0, 0, '0);
        // LM R1, mask A5: registers 0,2,5,7; the following ADD is held by fetch meanwhile
        add(16'hC2A5, 16'h0040, 0, 0, mk(1, 1, 16'h0040, 4'hC, 0, 1, 0, 16'd0, RW | MR, 0, 0));
        add(16'h1A4B, 16'h0042, 0, 0, mk(1, 1, 16'h0040, 4'hC, 2, 1, 0, 16'd1, RW | MR, 0, 0));
        add(16'h1A4B, 16'h0042, 0, 0, mk(1, 1, 16'h0040, 4'hC, 5, 1, 0, 16'd2, RW | MR, 0, 0));
        add(16'h1A4B, 16'h0042, 0, 0, mk(0, 1, 16'h0040, 4'hC, 7, 1, 0, 16'd3, RW | MR, 0, 0));
        add(16'h1A4B, 16'h0042, 0, 0, mk(0, 1, 16'h0042, 4'h1, 1, 5, 1, 16'd0, RW, 2'b11, 0));
        // SM R0, mask 03 with a two-cycle stall on the second micro-op
        add(16'hD003, 16'h0050, 0, 0, mk(1, 1, 16'h0050, 4'hD, 0, 0, 0, 16'd0, MW, 0, 0));
        add(16'h0A7E, 16'h0052, 0, 0, mk(0, 1, 16'h0050, 4'hD, 0, 0, 1, 16'd1, MW, 0, 0));
        add(16'h0A7E, 16'h0052, 0, 1, mk(1, 1, 16'h0050, 4'hD, 0, 0, 1, 16'd1, MW, 0, 0));
        add(16'h0A7E, 16'h0052, 0, 1, mk(1, 1, 16'h0050, 4'hD, 0, 0, 1, 16'd1, MW, 0, 0));
        add(16'h0A7E, 16'h0052, 0, 0, mk(0, 1, 16'h0052, 4'h0, 1, 5, 0, 16'hFFFE, RW, 0, 0));
        // LM mask FF aborted by flush on its second cycle
        add(16'hC4FF, 16'h0060, 0, 0, mk(1, 1, 16'h0060, 4'hC, 0, 2, 0, 16'd0, RW | MR, 0, 0));
        add(16'h1A4B, 16'h0062, 1, 0, '0);
        add(16'h1A4B, 16'h0062, 0, 0, mk(0, 1, 16'h0062, 4'h1, 1, 5, 1, 16'd0, RW, 2'b11, 0));
        add(16'hE000, 16'h0064, 0, 1, mk(1, 1, 16'h0062, 4'h1, 1, 5, 1, 16'd0, RW, 2'b11, 0));
        add(16'hE000, 16'h0064, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add(16'h0000, 16'h0066, 0, 0, '0);

        foreach (vt[i]) step($sformatf("vec%0d", i), vt[i].ins, vt[i].pc, vt[i].fl, vt[i].st, vt[i].ex);

        step("mr_uop0", 16'hC2A5, 16'h0080, 0, 0, mk(1, 1, 16'h0080, 4'hC, 0, 1, 0, 16'd0, RW | MR, 0, 0));
        step("mr_uop1", 16'h1A4B, 16'h0082, 0, 0, mk(1, 1, 16'h0080, 4'hC, 2, 1, 0, 16'd1, RW | MR, 0, 0));
        #3 resetn = 1'b0;
        #1 check("mr_reset", '0);
        @(negedge clk);
        resetn = 1'b1;
        step("mr_after", 16'h1A4B, 16'h0082, 0, 0, mk(0, 1, 16'h0082, 4'h1, 1, 5, 1, 16'd0, RW, 2'b11, 0));
        step("mr_bubble", 16'h0000, 16'h0084, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage with its own IF/ID pipeline register, placed directly downstream of the instruction-fetch stage.
- Each cycle it registers the fetched 16-bit instruction and its PC, then decodes the opcode into register addresses, a sign-extended immediate and control strobes for the execute stage.
- It expands LM/SM into one single-register micro-op per cycle.
- While that expansion runs, it holds fetch through fetch_hold.

Parameters:
- REG_AW, 3, register-address width (8 GPRs).
- IMM_W, 16, width of the extended immediate.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard the decoded instruction and abort any LM/SM sequence
- stall_in  in  1  downstream stall; freeze stage
- instr_in  in  16  instruction from fetch; 16'h0000 = bubble
- pc_in  in  16  PC of instr_in
- fetch_hold  out  1  fetch must freeze its PC and keep instr_in stable
- valid_out  out  1  decoded op valid
- pc_out  out  16  PC of the decoded op
- opcode_out  out  4  instr[15:12]
- rd_addr  out  3  destination register
- rs1_addr  out  3  source/base register
- rs2_addr  out  3  second source / store data register
- imm_out  out  16  extended immediate
- reg_write  out  1  op writes rd
- mem_read  out  1  load
- mem_write  out  1  store
- is_branch  out  1  BEQ
- is_jump  out  1  JAL/JLR/JRI
- cz_out  out  2  instr[1:0] condition bits for ADD/NDU
- illegal_out  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, resetn=0): every output register 0, state RUN, mask 0, micro-op count 0. fetch_hold = stall_in while in reset.
- fetch_hold = stall_in OR multi_busy. It is combinational from the registered multi_busy.
- Fields: RA=[11:9], RB=[8:6], RC=[5:3]. sext6 = sign-extend [5:0]; sext9 = sign-extend [8:0].
- Latency: outputs update one clk after instr_in is sampled.
- Priority at each posedge: flush > stall_in > normal.
- flush:
  - All outputs go to 0 (bubble).
  - State returns to RUN; mask, count and multi_busy are cleared.
  - The same-cycle instr_in is dropped.
- stall_in=1 (no flush): all outputs and internal state hold; instr_in is ignored.
- RUN, instr_in=16'h0000: bubble (valid_out=0, all strobes 0).
- RUN decode table (rd/rs fields not listed = 0):
  - 0001 ADD and 0010 NDU: rd=RC, rs1=RA, rs2=RB, reg_write, cz_out=[1:0].
  - 0000 ADI: rd=RB, rs1=RA, imm=sext6, reg_write.
  - 0011 LHI: rd=RA, imm={[8:0],7'b0}, reg_write.
  - 0100 LW: rd=RA, rs1=RB, imm=sext6, reg_write, mem_read.
  - 0101 SW: rs1=RB, rs2=RA, imm=sext6, mem_write.
  - 1000 BEQ: rs1=RA, rs2=RB, imm=sext6, is_branch.
  - 1001 JAL: rd=RA, imm=sext9, reg_write, is_jump.
  - 1010 JLR: rd=RA, rs1=RB, reg_write, is_jump.
  - 1011 JRI: rs1=RA, imm=sext9, is_jump.
  - Any other opcode: bubble, with illegal_out=1 for exactly one cycle.
- LM (1100) / SM (1101) in RUN:
  - mask = instr[7:0]. Bit i selects register Ri; bits are served lowest index first.
  - mask==0: emit bubble; no hold.
  - Otherwise emit micro-op 0 immediately:
    - rs1=RA (base), imm=count zero-extended.
    - LM: rd=i, reg_write=1, mem_read=1.
    - SM: rs2=i, mem_write=1.
    - pc_out = PC of the LM/SM instruction.
  - Clear that bit. If bits remain, go to MULTI with multi_busy=1.
- MULTI:
  - Each unstalled cycle, issue the next lowest set bit as a micro-op, with count incremented (3-bit, 0..7, never wraps for a valid 8-bit mask).
  - instr_in is ignored.
  - When the issued bit was the last one, return to RUN and clear multi_busy. The held instr_in is then sampled at the next edge.
- Fetch contract: fetch advances on the edge that captures LM/SM and then holds that following instruction while fetch_hold=1. No instruction is lost or duplicated.
- Stall in MULTI: the current micro-op stays on the outputs; the sequence resumes on release.
- Flush in MULTI: the remaining micro-ops are discarded.
- Reset mid-sequence: identical to power-on reset.

Test Plan:
- Reset with instr_in=16'h1A4B held: all outputs 0 while resetn=0. After release, one clk later: valid_out=1, opcode 0001, rs1=5, rs2=1, rd=1, cz_out=2'b11, reg_write=1.
- ADI 16'h0A7E (RA=5, RB=1, imm6=111110) -> rd=1, rs1=5, imm_out=16'hFFFE. JRI 16'hB1FF -> rs1=0, imm_out=16'hFFFF, is_jump=1.
- LM 16'hC2A5 (RA=1, mask 1010_0101):
  - Four micro-ops on consecutive cycles: rd=0,2,5,7 with imm=0,1,2,3, rs1=1, mem_read=1.
  - fetch_hold=1 for exactly 3 cycles.
  - The next held instruction appears on the cycle after rd=7.
- SM 16'hD003 with stall_in=1 for 2 cycles during the second micro-op -> outputs hold rs2=1, imm=1. No extra micro-op; fetch_hold stays 1 through the stall.
- flush asserted on the second cycle of LM mask 8'hFF -> next cycle bubble, fetch_hold=0, state RUN. The following instr_in decodes normally.
- Opcode 16'hE000 -> valid_out=0, illegal_out=1 for one cycle. 16'h0000 -> bubble with illegal_out=0. SM with mask 0 -> bubble, no hold.
